// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit: FSM states, cause codes,
// read-mux selects and ALU status bit positions.
package exception_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } exc_state_t;

  localparam logic [3:0] CAUSE_NONE     = 4'h0;
  localparam logic [3:0] CAUSE_DIV_ZERO = 4'h1;
  localparam logic [3:0] CAUSE_OVERFLOW = 4'h2;
  localparam logic [3:0] CAUSE_BAD_ADDR = 4'h3;

  localparam logic [1:0] SEL_CAUSE  = 2'd0;
  localparam logic [1:0] SEL_EPC    = 2'd1;
  localparam logic [1:0] SEL_STICKY = 2'd2;
  localparam logic [1:0] SEL_COUNT  = 2'd3;

  // Status byte layout: {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}
  localparam int BIT_ZERO     = 7;
  localparam int BIT_OVERFLOW = 6;
  localparam int BIT_BAD_ADDR = 3;
  localparam int BIT_DIV_ZERO = 2;

endpackage

// File: rtl/exc_cause_enc.sv
// Trap detection and cause priority encoder: div_zero > overflow > invalid_address.
// Overflow and address faults only count when the instruction class asks for them.
module exc_cause_enc
  import exception_unit_pkg::*;
(
  input  logic       valid,
  input  logic       div_zero,
  input  logic       overflow,
  input  logic       bad_addr,
  input  logic       check_ovf,
  input  logic       check_addr,
  output logic       trap,
  output logic [3:0] cause
);

  logic ovf_trap;
  logic addr_trap;

  assign ovf_trap  = overflow & check_ovf;
  assign addr_trap = bad_addr & check_addr;

  // Highest-priority qualified fault selects the cause code
  always_comb begin
    trap  = 1'b0;
    cause = CAUSE_NONE;
    if (valid) begin
      if (div_zero) begin
        trap  = 1'b1;
        cause = CAUSE_DIV_ZERO;
      end else if (ovf_trap) begin
        trap  = 1'b1;
        cause = CAUSE_OVERFLOW;
      end else if (addr_trap) begin
        trap  = 1'b1;
        cause = CAUSE_BAD_ADDR;
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception unit: traps on qualified ALU faults, redirects to the handler,
// and returns to EPC+4 on eret. Keeps sticky status flags and a saturating
// trap counter readable through a small read mux.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int          CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXC_valid,
  input  logic [7:0]  EXC_status,
  input  logic [31:0] EXC_pc,
  input  logic        EXC_check_ovf,
  input  logic        EXC_check_addr,
  input  logic        EXC_eret,
  input  logic [1:0]  EXC_read_sel,
  output logic        EXC_flush,
  output logic        EXC_redirect,
  output logic [31:0] EXC_target,
  output logic        EXC_busy,
  output logic [31:0] EXC_read_data
);

  exc_state_t       state_reg;
  logic [3:0]       cause_reg;
  logic [31:0]      epc_reg;
  logic [5:0]       sticky_reg;
  logic [CNT_W-1:0] count_reg;
  logic             flush_reg;
  logic             redirect_reg;
  logic [31:0]      target_reg;

  logic             trap;
  logic [3:0]       enc_cause;
  logic [31:0]      count_ext;
  logic             unused_status_lsbs;

  // Two low status bits are reserved zeros and carry no information
  assign unused_status_lsbs = ^EXC_status[1:0];

  exc_cause_enc u_cause_enc (
    .valid      (EXC_valid),
    .div_zero   (EXC_status[BIT_DIV_ZERO]),
    .overflow   (EXC_status[BIT_OVERFLOW]),
    .bad_addr   (EXC_status[BIT_BAD_ADDR]),
    .check_ovf  (EXC_check_ovf),
    .check_addr (EXC_check_addr),
    .trap       (trap),
    .cause      (enc_cause)
  );

  // Control FSM; flush/redirect/target are registered so they line up with FLUSH and RETURN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cause_reg    <= CAUSE_NONE;
      epc_reg      <= '0;
      count_reg    <= '0;
      flush_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
    end else begin
      flush_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (trap) begin
            state_reg    <= ST_FLUSH;
            cause_reg    <= enc_cause;
            epc_reg      <= EXC_pc;
            flush_reg    <= 1'b1;
            redirect_reg <= 1'b1;
            target_reg   <= HANDLER_ADDR;
            if (count_reg != {CNT_W{1'b1}}) begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          state_reg <= ST_HANDLER;
        end
        ST_HANDLER: begin
          // No nesting: a trap here is dropped, eret alone decides
          if (EXC_eret) begin
            state_reg    <= ST_RETURN;
            flush_reg    <= 1'b1;
            redirect_reg <= 1'b1;
            target_reg   <= epc_reg + 32'd4;
          end
        end
        ST_RETURN: begin
          state_reg <= ST_IDLE;
          cause_reg <= CAUSE_NONE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags accumulate every valid status byte regardless of FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_reg <= '0;
    end else if (EXC_valid) begin
      sticky_reg <= sticky_reg | EXC_status[BIT_ZERO:BIT_DIV_ZERO];
    end
  end

  // Zero-extend the counter to the 32-bit read bus
  always_comb begin
    count_ext              = '0;
    count_ext[CNT_W-1:0]   = count_reg;
  end

  // Combinational read mux
  always_comb begin
    EXC_read_data = '0;
    case (EXC_read_sel)
      SEL_CAUSE:  EXC_read_data = {28'd0, cause_reg};
      SEL_EPC:    EXC_read_data = epc_reg;
      SEL_STICKY: EXC_read_data = {26'd0, sticky_reg};
      SEL_COUNT:  EXC_read_data = count_ext;
      default:    EXC_read_data = '0;
    endcase
  end

  assign EXC_flush    = flush_reg;
  assign EXC_redirect = redirect_reg;
  assign EXC_target   = target_reg;
  assign EXC_busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_exception_unit.sv
// Testbench for exception_unit: directed vector table, asynchronous reset
// sequences, counter saturation, and randomized cycles against a reference model.
module tb_exception_unit;

  localparam logic [31:0] HA   = 32'h8000_0180;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic        clk;
  logic        reset;
  logic        EXC_valid;
  logic [7:0]  EXC_status;
  logic [31:0] EXC_pc;
  logic        EXC_check_ovf;
  logic        EXC_check_addr;
  logic        EXC_eret;
  logic [1:0]  EXC_read_sel;
  logic        EXC_flush;
  logic        EXC_redirect;
  logic [31:0] EXC_target;
  logic        EXC_busy;
  logic [31:0] EXC_read_data;

  int n_vec = 0;
  int n_bad = 0;

  exception_unit #(.HANDLER_ADDR(HA), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .EXC_valid      (EXC_valid),
    .EXC_status     (EXC_status),
    .EXC_pc         (EXC_pc),
    .EXC_check_ovf  (EXC_check_ovf),
    .EXC_check_addr (EXC_check_addr),
    .EXC_eret       (EXC_eret),
    .EXC_read_sel   (EXC_read_sel),
    .EXC_flush      (EXC_flush),
    .EXC_redirect   (EXC_redirect),
    .EXC_target     (EXC_target),
    .EXC_busy       (EXC_busy),
    .EXC_read_data  (EXC_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  st;
    logic [31:0] pc;
    logic        ovf;
    logic        addr;
    logic        eret;
    logic        redir;
    logic [31:0] tgt;
    logic        busy;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [5:0]  sticky;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[19];

  // Reference model state (abstract: "exception in progress" plus the two redirect cycles)
  bit          m_exc, m_entry, m_exit;
  logic [3:0]  m_cause;
  logic [31:0] m_epc;
  logic [5:0]  m_sticky;
  int          m_count;

  function automatic vec_t mk(logic v, logic [7:0] st, logic [31:0] pc, logic ovf, logic addr,
                              logic eret, logic redir, logic [31:0] tgt, logic busy,
                              logic [3:0] cause, logic [31:0] epc, logic [5:0] sticky, logic [3:0] cnt);
    vec_t r;
    r.v = v; r.st = st; r.pc = pc; r.ovf = ovf; r.addr = addr; r.eret = eret;
    r.redir = redir; r.tgt = tgt; r.busy = busy; r.cause = cause; r.epc = epc;
    r.sticky = sticky; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic redir, input logic [31:0] tgt,
                           input logic busy, input logic [3:0] cause, input logic [31:0] epc,
                           input logic [5:0] sticky, input logic [3:0] cnt);
    chk({nm, ".flush"},    {31'd0, EXC_flush},    {31'd0, redir});
    chk({nm, ".redirect"}, {31'd0, EXC_redirect}, {31'd0, redir});
    chk({nm, ".target"},   EXC_target, tgt);
    chk({nm, ".busy"},     {31'd0, EXC_busy},     {31'd0, busy});
    EXC_read_sel = 2'd0; #1; chk({nm, ".cause"},  EXC_read_data, {28'd0, cause});
    EXC_read_sel = 2'd1; #1; chk({nm, ".epc"},    EXC_read_data, epc);
    EXC_read_sel = 2'd2; #1; chk({nm, ".sticky"}, EXC_read_data, {26'd0, sticky});
    EXC_read_sel = 2'd3; #1; chk({nm, ".count"},  EXC_read_data, {28'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] st, input logic [31:0] pc,
                       input logic ovf, input logic addr, input logic eret);
    EXC_valid = v; EXC_status = st; EXC_pc = pc;
    EXC_check_ovf = ovf; EXC_check_addr = addr; EXC_eret = eret;
  endtask

  task automatic model_reset();
    m_exc = 0; m_entry = 0; m_exit = 0;
    m_cause = 4'h0; m_epc = 32'h0; m_sticky = 6'h0; m_count = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs currently driven
  task automatic model_step();
    bit          was_idle, in_handler, trap;
    logic [3:0]  code;
    was_idle   = !m_exc;
    in_handler = m_exc && !m_entry && !m_exit;
    code = 4'h0;
    if (EXC_valid) begin
      if (EXC_status[2])                        code = 4'h1;
      else if (EXC_status[6] && EXC_check_ovf)  code = 4'h2;
      else if (EXC_status[3] && EXC_check_addr) code = 4'h3;
      m_sticky = m_sticky | EXC_status[7:2];
    end
    trap = (code != 4'h0);
    if (m_exit) begin
      m_exc = 0;
      m_cause = 4'h0;
    end
    m_entry = 0;
    m_exit  = 0;
    if (was_idle && trap) begin
      m_exc = 1; m_entry = 1; m_cause = code; m_epc = EXC_pc;
      if (m_count < CMAX) m_count++;
    end else if (in_handler && EXC_eret) begin
      m_exit = 1;
    end
  endtask

  task automatic model_check(input string nm);
    logic [31:0] tgt;
    tgt = m_entry ? HA : (m_exit ? m_epc + 32'd4 : 32'd0);
    check_all(nm, m_entry | m_exit, tgt, m_exc, m_cause, m_epc, m_sticky, 4'(m_count));
  endtask

  task automatic hard_reset(input string nm);
    reset = 1'b1;
    #1;
    model_reset();
    model_check(nm);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 32'h0, 0, 0, 0);
    EXC_read_sel = 2'd0;
    model_reset();

    //            v  st     pc            ovf addr eret | redir tgt           busy cause epc           sticky cnt
    tbl[0]  = mk(1, 8'h40, 32'h0000_0100, 0, 0, 0,  0, 32'h0,         0, 4'h0, 32'h0,         6'h10, 4'd0);
    tbl[1]  = mk(1, 8'h40, 32'h0000_0200, 1, 0, 0,  1, HA,            1, 4'h2, 32'h0000_0200, 6'h10, 4'd1);
    tbl[2]  = mk(0, 8'h00, 32'h0,         0, 0, 1,  0, 32'h0,         1, 4'h2, 32'h0000_0200, 6'h10, 4'd1);
    tbl[3]  = mk(0, 8'h00, 32'h0,         0, 0, 1,  1, 32'h0000_0204, 1, 4'h2, 32'h0000_0200, 6'h10, 4'd1);
    tbl[4]  = mk(0, 8'h00, 32'h0,         0, 0, 0,  0, 32'h0,         0, 4'h0, 32'h0000_0200, 6'h10, 4'd1);
    tbl[5]  = mk(1, 8'h04, 32'h0040_0010, 0, 0, 0,  1, HA,            1, 4'h1, 32'h0040_0010, 6'h11, 4'd2);
    tbl[6]  = mk(0, 8'h00, 32'h0,         0, 0, 0,  0, 32'h0,         1, 4'h1, 32'h0040_0010, 6'h11, 4'd2);
    tbl[7]  = mk(0, 8'h00, 32'h0,         0, 0, 1,  1, 32'h0040_0014, 1, 4'h1, 32'h0040_0010, 6'h11, 4'd2);
    tbl[8]  = mk(0, 8'h00, 32'h0,         0, 0, 1,  0, 32'h0,         0, 4'h0, 32'h0040_0010, 6'h11, 4'd2);
    tbl[9]  = mk(0, 8'h00, 32'h0,         0, 0, 1,  0, 32'h0,         0, 4'h0, 32'h0040_0010, 6'h11, 4'd2);
    tbl[10] = mk(1, 8'h4C, 32'h0000_0300, 1, 1, 0,  1, HA,            1, 4'h1, 32'h0000_0300, 6'h13, 4'd3);
    tbl[11] = mk(1, 8'h04, 32'h0000_0500, 0, 0, 1,  0, 32'h0,         1, 4'h1, 32'h0000_0300, 6'h13, 4'd3);
    tbl[12] = mk(1, 8'h04, 32'h0000_0400, 0, 0, 1,  1, 32'h0000_0304, 1, 4'h1, 32'h0000_0300, 6'h13, 4'd3);
    tbl[13] = mk(1, 8'h08, 32'h0000_0600, 0, 0, 0,  0, 32'h0,         0, 4'h0, 32'h0000_0300, 6'h13, 4'd3);
    tbl[14] = mk(1, 8'h08, 32'h0000_0700, 0, 1, 0,  1, HA,            1, 4'h3, 32'h0000_0700, 6'h13, 4'd4);
    tbl[15] = mk(1, 8'h80, 32'h0000_0800, 0, 0, 0,  0, 32'h0,         1, 4'h3, 32'h0000_0700, 6'h33, 4'd4);
    tbl[16] = mk(0, 8'h04, 32'h0000_0900, 0, 0, 0,  0, 32'h0,         1, 4'h3, 32'h0000_0700, 6'h33, 4'd4);
    tbl[17] = mk(0, 8'h00, 32'h0,         0, 0, 1,  1, 32'h0000_0704, 1, 4'h3, 32'h0000_0700, 6'h33, 4'd4);
    tbl[18] = mk(0, 8'h04, 32'h0000_0a00, 0, 0, 0,  0, 32'h0,         0, 4'h0, 32'h0000_0700, 6'h33, 4'd4);

    // Reset state
    tick();
    tick();
    check_all("reset", 0, 32'h0, 0, 4'h0, 32'h0, 6'h0, 4'd0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].pc, tbl[i].ovf, tbl[i].addr, tbl[i].eret);
      tick();
      drive(0, 8'h00, 32'h0, 0, 0, 0);
      $display("row %0d: v=%0d st=%h pc=%h eret=%0d -> redir=%0d tgt=%h busy=%0d",
               i, tbl[i].v, tbl[i].st, tbl[i].pc, tbl[i].eret, EXC_redirect, EXC_target, EXC_busy);
      check_all($sformatf("row%0d", i), tbl[i].redir, tbl[i].tgt, tbl[i].busy,
                tbl[i].cause, tbl[i].epc, tbl[i].sticky, tbl[i].cnt);
    end

    // Asynchronous reset while in FLUSH: outputs drop without a clock edge
    drive(1, 8'h04, 32'h0000_1000, 0, 0, 0);
    tick();
    drive(0, 8'h00, 32'h0, 0, 0, 0);
    chk("flush_before_rst", {31'd0, EXC_flush}, 32'd1);
    hard_reset("rst_in_flush");
    $display("reset asserted in FLUSH");

    // Asynchronous reset while in HANDLER
    drive(1, 8'h04, 32'h0000_2000, 0, 0, 0);
    tick();
    drive(0, 8'h00, 32'h0, 0, 0, 0);
    tick();
    chk("busy_in_handler", {31'd0, EXC_busy}, 32'd1);
    hard_reset("rst_in_handler");
    $display("reset asserted in HANDLER");

    // Counter saturation at all-ones
    for (int k = 0; k < 16; k++) begin
      drive(1, 8'h04, 32'(k * 4), 0, 0, 0); tick();
      drive(0, 8'h00, 32'h0, 0, 0, 0);      tick();
      drive(0, 8'h00, 32'h0, 0, 0, 1);      tick();
      drive(0, 8'h00, 32'h0, 0, 0, 0);      tick();
      EXC_read_sel = 2'd3; #1;
      $display("sat round %0d: count=%0d", k, EXC_read_data);
      chk($sformatf("sat_count%0d", k), EXC_read_data, (k + 1 > CMAX) ? CMAX : k + 1);
    end

    // Randomized cycles against the reference model
    hard_reset("rnd_start");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        hard_reset($sformatf("rnd%0d.rst", i));
        $display("rnd %0d: reset", i);
      end else begin
        drive($urandom_range(0, 3) != 0,
              8'($urandom) & (($urandom_range(0, 2) == 0) ? 8'hFC : 8'hB0),
              $urandom,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0);
        model_step();
        tick();
        $display("rnd %0d: v=%0d st=%h eret=%0d -> redir=%0d tgt=%h busy=%0d",
                 i, EXC_valid, EXC_status, EXC_eret, EXC_redirect, EXC_target, EXC_busy);
        model_check($sformatf("rnd%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
